dsp_accum_stim_checker: RTL

On-chip stimulus generator and self-checker for the 20x18 shift-subtract accumulator DSP primitive (z = (a<<19) − z_prev[19:0]·b, 38-bit registered output). It drives the DUT's `a`, `b` and reset inputs, runs a bit-exact reference model of the DUT, and compares `z_out` every cycle. It reports a mismatch count and a pass/fail verdict, so hardware bring-up runs without a simulator testbench.

---
 rtl/dsp_accum_stim_checker.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/dsp_accum_stim_checker.sv
// Stimulus generator and bit-exact self-checker for the 20x18 shift-subtract
// accumulator DSP primitive: z = (a<<19) - z_prev[19:0]*b, 38-bit registered.
module dsp_accum_stim_checker #(
  parameter int          NUM_VECTORS  = 14,
  parameter int          DIRECTED_EN  = 1,
  parameter logic [31:0] LFSR_SEED    = 32'hACE12468,
  parameter int          RESET_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [37:0] z_in,
  output logic [19:0] a_out,
  output logic [17:0] b_out,
  output logic        dut_reset,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] mismatch_cnt,
  output logic [15:0] vec_cnt,
  output logic        err_valid,
  output logic [37:0] err_expected,
  output logic [37:0] err_actual
);

  localparam logic [31:0] LFSR_TAPS    = 32'h80200003;
  localparam int          NUM_DIRECTED = (DIRECTED_EN != 0) ?
                                         ((NUM_VECTORS < 4) ? NUM_VECTORS : 4) : 0;
  localparam int          IW           = $clog2(NUM_VECTORS + 2);
  localparam int          RW           = $clog2(RESET_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    DUT_RST,
    RST_CHK,
    RUN,
    DRAIN,
    DONE
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [RW-1:0] rst_cnt;
  logic [IW-1:0] issue_idx;
  logic [31:0]   lfsr;
  logic [31:0]   lfsr_step;
  logic          issue;
  logic          directed;
  logic [19:0]   vec_a;
  logic [17:0]   vec_b;
  logic [37:0]   exp_z;
  logic [37:0]   prod;
  logic [37:0]   exp_z_next;
  logic          cmp_en;
  logic [37:0]   cmp_ref;
  logic          mismatch;
  logic          clear;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DUT_RST;
      DUT_RST: if (rst_cnt == RW'(RESET_CYCLES - 1)) state_next = RST_CHK;
      RST_CHK: state_next = RUN;
      RUN:     if (issue_idx == IW'(NUM_VECTORS)) state_next = DRAIN;
      DRAIN:   state_next = DONE;
      DONE:    if (start) state_next = DUT_RST;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    dut_reset = reset || (state == DUT_RST) || (state == RST_CHK);
    busy      = (state != IDLE) && (state != DONE);
    done      = (state == DONE);
    pass      = (state == DONE) && (mismatch_cnt == 16'd0);
  end

  always_ff @(posedge clk) begin
    if (reset || state != DUT_RST) begin
      rst_cnt <= '0;
    end else begin
      rst_cnt <= rst_cnt + RW'(1);
    end
  end

  // Vector source: the directed table first, then one LFSR advance per random vector.
  assign lfsr_step = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 32'd0);
  assign issue     = (state_next == RUN);

  always_comb begin
    directed = (issue_idx < IW'(NUM_DIRECTED));
    vec_a    = lfsr_step[19:0];
    vec_b    = lfsr_step[31:14];
    if (directed) begin
      case (issue_idx[1:0])
        2'd0:    begin vec_a = 20'h00007; vec_b = 18'h00003; end
        2'd1:    begin vec_a = 20'h7FFFF; vec_b = 18'h1FFFF; end
        2'd2:    begin vec_a = 20'h80000; vec_b = 18'h20000; end
        default: begin vec_a = 20'd417393; vec_b = 18'd109048; end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_out     <= '0;
      b_out     <= '0;
      issue_idx <= '0;
      lfsr      <= LFSR_SEED;
    end else if (issue) begin
      a_out     <= vec_a;
      b_out     <= vec_b;
      issue_idx <= issue_idx + IW'(1);
      if (!directed) begin
        lfsr <= lfsr_step;
      end
    end else if (state == IDLE || state_next == DUT_RST) begin
      a_out     <= '0;
      b_out     <= '0;
      issue_idx <= '0;
      lfsr      <= LFSR_SEED;
    end
  end

  // Only 38 result bits matter, so a_out[19] (worth 2^38) drops out of the shift.
  assign prod       = 38'(exp_z[19:0]) * 38'(b_out);
  assign exp_z_next = {a_out[18:0], 19'd0} - prod;

  always_ff @(posedge clk) begin
    if (reset) begin
      exp_z <= '0;
    end else if (state == RUN) begin
      exp_z <= exp_z_next;
    end else if (state == IDLE || state == DUT_RST) begin
      exp_z <= '0;
    end
  end

  // The first RUN cycle still sees the reset DUT output, so it is skipped.
  assign cmp_en   = (state == RST_CHK) || (state == DRAIN) ||
                    ((state == RUN) && (issue_idx != IW'(1)));
  assign cmp_ref  = (state == RST_CHK) ? 38'd0 : exp_z;
  assign mismatch = cmp_en && (z_in != cmp_ref);
  assign clear    = (state == IDLE) || ((state == DONE) && start);

  always_ff @(posedge clk) begin
    if (reset) begin
      err_valid <= 1'b0;
    end else begin
      err_valid <= mismatch;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      vec_cnt      <= '0;
      mismatch_cnt <= '0;
      err_expected <= '0;
      err_actual   <= '0;
    end else begin
      if (cmp_en) begin
        vec_cnt <= vec_cnt + 16'd1;
      end
      if (mismatch) begin
        if (mismatch_cnt != 16'hFFFF) begin
          mismatch_cnt <= mismatch_cnt + 16'd1;
        end
        err_expected <= cmp_ref;
        err_actual   <= z_in;
      end
    end
  end

endmodule
